// File: rtl/nrad_handshake.sv
// Valid/ready front-end and result register for the 4-bit by 2-bit non-restoring array divider.
// Optional result self-check is enabled by defining NRAD_CHECK_EN.
module nrad_handshake #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_x,
    input  logic [1:0] in_y,
    output logic [3:0] div_x,
    output logic [1:0] div_y,
    input  logic [2:0] div_q,
    input  logic [2:0] div_r,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_q,
    output logic [2:0] out_r,
    output logic       out_dz,
    output logic       out_err
);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q;
    logic       transfer;
    logic       capture;
    logic       out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = (in_y == 2'd0) ? StHold : StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StIdle) && !reset;
        transfer = in_ready && in_valid;
        capture  = (state_q == StSettle) && (cnt_q == 4'd0);
    end

    assign out_valid = out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            cnt_q       <= 4'd0;
            div_x       <= 4'd0;
            div_y       <= 2'd0;
            out_q       <= 3'd0;
            out_r       <= 3'd0;
            out_dz      <= 1'b0;
        end else begin
            out_valid_q <= (state_d == StHold);
            if (transfer) begin
                div_x <= in_x;
                div_y <= in_y;
                if (in_y == 2'd0) begin
                    out_q  <= 3'd0;
                    out_r  <= 3'd0;
                    out_dz <= 1'b1;
                end else begin
                    out_dz <= 1'b0;
                    cnt_q  <= 4'(SETTLE_CYCLES - 1);
                end
            end else if (capture) begin
                out_q <= div_q;
                out_r <= div_r;
            end else if (state_q == StSettle) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

`ifdef NRAD_CHECK_EN
    // Array result must satisfy q*y + r == x with r < y; quotient overflow also flags.
    logic [5:0] chk_sum;
    logic       chk_err;
    logic       out_err_q;

    always_comb begin
        chk_sum = ({3'b000, div_q} * {4'b0000, div_y}) + {3'b000, div_r};
        chk_err = (chk_sum != {2'b00, div_x}) || (div_r >= {1'b0, div_y});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_err_q <= 1'b0;
        end else if (transfer && (in_y == 2'd0)) begin
            out_err_q <= 1'b0;
        end else if (capture) begin
            out_err_q <= chk_err;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_nrad_handshake.sv
// Randomized and directed bench for nrad_handshake with a transaction-level reference model.
module tb_nrad_handshake;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_x = 4'd0;
    logic [1:0] in_y = 2'd0;
    logic [3:0] div_x;
    logic [1:0] div_y;
    logic [2:0] div_q;
    logic [2:0] div_r;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_q;
    logic [2:0] out_r;
    logic       out_dz;
    logic       out_err;
    logic       stub = 1'b0;

    int checks = 0;
    int errors = 0;

    nrad_handshake #(.SETTLE_CYCLES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .div_x    (div_x),
        .div_y    (div_y),
        .div_q    (div_q),
        .div_r    (div_r),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_q    (out_q),
        .out_r    (out_r),
        .out_dz   (out_dz),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    // Behavioural divider array (3-bit quotient truncates), or a deliberately wrong stub.
    always_comb begin
        if (stub) begin
            div_q = 3'd5;
            div_r = 3'd1;
        end else if (div_y == 2'd0) begin
            div_q = 3'd0;
            div_r = 3'd0;
        end else begin
            div_q = 3'(div_x / {2'b00, div_y});
            div_r = 3'(div_x % {2'b00, div_y});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a held result, or a number of edges left before one appears.
    bit m_init = 0;
    bit m_hold = 0;
    int m_left = 0;
    int m_x = 0, m_y = 0, m_q = 0, m_r = 0, m_dz = 0, m_err = 0;
    int p_q = 0, p_r = 0, p_err = 0;

    function automatic int expect_err(int q, int r, int x, int y);
`ifdef NRAD_CHECK_EN
        return ((q * y + r) != x || r >= y) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1;
            m_hold = 0;
            m_left = 0;
            m_x = 0; m_y = 0; m_q = 0; m_r = 0; m_dz = 0; m_err = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hold = 1;
                m_q = p_q;
                m_r = p_r;
                m_err = p_err;
            end
        end else if (in_valid) begin
            m_x = int'(in_x);
            m_y = int'(in_y);
            if (m_y == 0) begin
                m_q = 0; m_r = 0; m_dz = 1; m_err = 0;
                m_hold = 1;
            end else begin
                m_dz = 0;
                if (stub) begin
                    p_q = 5;
                    p_r = 1;
                end else begin
                    p_q = (m_x / m_y) % 8;
                    p_r = m_x % m_y;
                end
                p_err = expect_err(p_q, p_r, m_x, m_y);
                m_left = S;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", 32'(in_ready), 32'(!reset && !m_hold && m_left == 0));
            chk("out_valid", 32'(out_valid), 32'(m_hold));
            chk("div_x", 32'(div_x), m_x);
            chk("div_y", 32'(div_y), m_y);
            chk("out_q", 32'(out_q), m_q);
            chk("out_r", 32'(out_r), m_r);
            chk("out_dz", 32'(out_dz), m_dz);
            chk("out_err", 32'(out_err), m_err);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] x, input logic [1:0] y);
        int t;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        t = 0;
        while (!in_ready && t < 100) begin
            cyc(1);
            t++;
        end
        if (t >= 100) chk("send_timeout", 32'(t), 0);
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int waited);
        waited = 0;
        while (!out_valid && waited < 100) begin
            cyc(1);
            waited++;
        end
        if (waited >= 100) chk("result_timeout", 32'(waited), 0);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
    endtask

    initial begin
        int w;
        int eq, er;
        cyc(3);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_q", 32'(out_q), 0);
        reset = 1'b0;
        cyc(1);

        send(4'd13, 2'd3);
        wait_result(w);
        chk("lat_13_3", 32'(w), S);
        chk("q_13_3", 32'(out_q), 4);
        chk("r_13_3", 32'(out_r), 1);
        chk("dz_13_3", 32'(out_dz), 0);
        chk("err_13_3", 32'(out_err), 0);
        accept();

        send(4'd9, 2'd0);
        wait_result(w);
        chk("lat_9_0", 32'(w), 0);
        chk("q_9_0", 32'(out_q), 0);
        chk("dz_9_0", 32'(out_dz), 1);
        accept();

        stub = 1'b1;
        send(4'd13, 2'd3);
        wait_result(w);
`ifdef NRAD_CHECK_EN
        chk("err_stub", 32'(out_err), 1);
`else
        chk("err_stub", 32'(out_err), 0);
`endif
        accept();
        stub = 1'b0;

        send(4'd15, 2'd2);
        wait_result(w);
        in_valid = 1'b1;
        in_x = 4'd3;
        in_y = 2'd1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_q", 32'(out_q), 7);
            chk("hold_r", 32'(out_r), 1);
            chk("hold_div_x", 32'(div_x), 15);
        end
        in_valid = 1'b0;
        accept();
        chk("post_accept_ready", 32'(in_ready), 1);
        chk("post_accept_valid", 32'(out_valid), 0);

        send(4'd6, 2'd2);
        reset = 1'b1;
        cyc(1);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_div_x", 32'(div_x), 0);
        reset = 1'b0;
        cyc(1);
        chk("abort_ready", 32'(in_ready), 1);
        chk("abort_valid2", 32'(out_valid), 0);

        out_ready = 1'b1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 4; y++) begin
                send(4'(x), 2'(y));
                wait_result(w);
                eq = (x / y) % 8;
                er = x % y;
                chk("sweep_q", 32'(out_q), eq);
                chk("sweep_r", 32'(out_r), er);
                chk("sweep_err", 32'(out_err), expect_err(eq, er, x, y));
                cyc(1);
            end
        end
        out_ready = 1'b0;

        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_x = 4'($urandom_range(0, 15));
            in_y = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 39) == 0);
            cyc(1);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc(S + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
